enc_gray_sequencer: RTL and testbench

ENC_GRAY_SEQUENCER -- requirements
Module: enc_gray_sequencer

---
 rtl/enc_pkg.sv | 20 ++
 rtl/enc_bin2gray.sv | 17 +
 rtl/enc_gray_sequencer.sv | 112 +++++++++++
 tb/tb_enc_gray_sequencer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : enc_pkg
//  Description : Shared state encoding and default widths for the Gray
//                code sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package enc_pkg;

  localparam int c_WIDTH_DEF = 10;
  localparam int c_CNT_W_DEF = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/enc_bin2gray.sv
`default_nettype none
// ============================================================================
//  Module      : enc_bin2gray
//  Description : Purely combinational binary to reflected-Gray converter.
//  Revision    : 1.0 - initial release
// ============================================================================
module enc_bin2gray #(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] i_bin,
  output logic [WIDTH-1:0] o_gray
);

  assign o_gray = i_bin ^ (i_bin >> 1);

endmodule
`default_nettype wire

// File: rtl/enc_gray_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : enc_gray_sequencer
//  Description : Emits count consecutive binary values from base, with their
//                Gray codes, over a valid/ready stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module enc_gray_sequencer
  import enc_pkg::*;
#(
  parameter int WIDTH = c_WIDTH_DEF,
  parameter int CNT_W = c_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [CNT_W-1:0] count,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bin,
  output logic [WIDTH-1:0] out_gray,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  logic [WIDTH-1:0] r_counter;
  logic [CNT_W-1:0] r_remaining;
  logic             r_valid;
  logic             r_last;
  logic             r_done;
  logic             w_handshake;

  assign w_handshake = r_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_counter   <= '0;
      r_remaining <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            if (count != '0) begin
              r_state     <= ST_RUN;
              r_counter   <= base;
              r_remaining <= count;
              r_valid     <= 1'b1;
              r_last      <= (count == CNT_W'(1));
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // Abort wins over a handshake in the same cycle.
          if (abort) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
          end else if (w_handshake) begin
            if (r_last) begin
              r_state     <= ST_DONE;
              r_valid     <= 1'b0;
              r_last      <= 1'b0;
              r_done      <= 1'b1;
              r_remaining <= '0;
            end else begin
              r_counter   <= r_counter + WIDTH'(1);
              r_remaining <= r_remaining - CNT_W'(1);
              r_last      <= (r_remaining == CNT_W'(2));
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  enc_bin2gray #(
    .WIDTH (WIDTH)
  ) u_bin2gray (
    .i_bin  (r_counter),
    .o_gray (out_gray)
  );

  assign out_valid = r_valid;
  assign out_bin   = r_counter;
  assign out_last  = r_last;
  assign done      = r_done;
  assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_enc_gray_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_enc_gray_sequencer
//  Description : Randomized self-checking bench with an index-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_enc_gray_sequencer;

  localparam int c_W  = 10;
  localparam int c_CW = 11;
  localparam int c_MOD = 1 << c_W;

  logic            clk;
  logic            rst;
  logic            start;
  logic [c_W-1:0]  base;
  logic [c_CW-1:0] count;
  logic            abort;
  logic            out_valid;
  logic            out_ready;
  logic [c_W-1:0]  out_bin;
  logic [c_W-1:0]  out_gray;
  logic            out_last;
  logic            busy;
  logic            done;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: a sequence is its base, its length and the index of the current beat.
  bit m_active;
  bit m_done;
  int m_base;
  int m_len;
  int m_idx;

  enc_gray_sequencer #(
    .WIDTH (c_W),
    .CNT_W (c_CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base      (base),
    .count     (count),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .out_gray  (out_gray),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [c_W-1:0] gray_of(input int v);
    logic [c_W-1:0] b;
    logic [c_W-1:0] g;
    b = c_W'(v);
    g[c_W-1] = b[c_W-1];
    for (int i = 0; i < c_W-1; i++) g[i] = b[i+1] ^ b[i];
    return g;
  endfunction

  task automatic step(input logic s, input int b, input int c,
                      input logic ab, input logic rd, input logic rs);
    int v;
    start = s; base = c_W'(b); count = c_CW'(c);
    abort = ab; out_ready = rd; rst = rs;
    @(posedge clk);
    if (rs) begin
      m_active = 0; m_done = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_active) begin
      if (s) begin
        if (c == 0) m_done = 1;
        else begin
          m_active = 1; m_base = b; m_len = c; m_idx = 0;
        end
      end
    end else if (ab) begin
      m_active = 0;
    end else if (rd) begin
      if (m_idx == m_len - 1) begin
        m_active = 0; m_done = 1;
      end else m_idx++;
    end
    #1;
    chk("valid", 32'(out_valid), 32'(m_active));
    chk("busy",  32'(busy), 32'(m_active | m_done));
    chk("done",  32'(done), 32'(m_done));
    if (m_active) begin
      v = (m_base + m_idx) % c_MOD;
      chk("bin",  32'(out_bin), 32'(v));
      chk("gray", 32'(out_gray), 32'(gray_of(v)));
      chk("last", 32'(out_last), 32'(m_idx == m_len - 1));
    end else begin
      chk("last_idle", 32'(out_last), 32'd0);
    end
    if (rs) chk("rst_bin", 32'(out_bin), 32'd0);
  endtask

  initial begin
    int cnt;
    int bs;
    m_active = 0; m_done = 0; m_base = 0; m_len = 0; m_idx = 0;
    start = 0; base = '0; count = '0; abort = 0; out_ready = 0; rst = 1;
    repeat (2) step(0, 0, 0, 0, 0, 1);

    // Four beats from zero at full throughput.
    step(1, 0, 4, 0, 1, 0);
    repeat (6) step(0, 0, 0, 0, 1, 0);
    // Wrap across the top of the code space.
    step(1, 1022, 3, 0, 1, 0);
    repeat (5) step(0, 0, 0, 0, 1, 0);
    // Back-pressure on the first beat.
    step(1, 5, 2, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 1, 0);
    // Zero-length request.
    step(1, 77, 0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0, 1, 0);
    // Abort on second beat, then a clean restart.
    step(1, 100, 8, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    step(1, 300, 2, 0, 1, 0);
    repeat (4) step(0, 0, 0, 0, 1, 0);
    // Reset on second beat, then a clean restart.
    step(1, 200, 8, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 1);
    step(1, 400, 3, 0, 1, 0);
    repeat (5) step(0, 0, 0, 0, 1, 0);
    // Start while busy is ignored.
    step(1, 10, 5, 0, 1, 0);
    step(1, 900, 2, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    repeat (7) step(0, 0, 0, 0, 1, 0);
    // Full-range sequence.
    step(1, 513, 1024, 0, 1, 0);
    repeat (1030) step(0, 0, 0, 0, 1, 0);

    for (int k = 0; k < 5000; k++) begin
      cnt = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 9));
      if ($urandom_range(0, 399) == 0) cnt = 1024;
      bs = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, c_MOD-1))
                                       : int'($urandom_range(c_MOD-4, c_MOD-1));
      step(($urandom_range(0, 3) == 0), bs, cnt,
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 499) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
